// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low gfedcba glyphs for hex digits,
// the blank pattern, and the sniffer FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} sniff_state_t;

  // Digit number for an active-low one-hot anode select.
  function automatic logic [1:0] sel_index(input logic [3:0] sel_n);
    case (sel_n)
      4'b1101: sel_index = 2'd1;
      4'b1011: sel_index = 2'd2;
      4'b0111: sel_index = 2'd3;
      default: sel_index = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_ca_decode.sv
// Combinational glyph-to-nibble decoder for common-anode segment patterns.
module seg7_ca_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       known,
  output logic       blank
);

  always_comb begin
    nibble = 4'h0;
    known  = 1'b1;
    blank  = 1'b0;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: begin known = 1'b0; blank = 1'b1; end
      default:   known = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_ca_sniffer.sv
// Sniffs a multiplexed common-anode 4-digit display and recovers the hex value.
// Define SEG7_SNIFF_DP_EN to also capture decimal points onto dp_out.
module seg7_ca_sniffer
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  Segments,
  input  logic        dp,
  input  logic [3:0]  SEL,
  output logic [15:0] HEX_out,
  output logic [3:0]  valid,
  output logic        err,
  output logic        frame_done
`ifdef SEG7_SNIFF_DP_EN
  ,
  output logic [3:0]  dp_out
`endif
);

  // Capture fires on the edge where the counter reaches STABLE_CYCLES-1.
  localparam logic [7:0] CAP_AT = 8'(STABLE_CYCLES - 2);

  logic [6:0]       s_seg, p_seg;
  logic [3:0]       s_sel, p_sel;
  logic [3:0][3:0]  hex_q;
  logic [3:0]       seen, seen_upd;
  logic [7:0]       cnt, cnt_nx;
  sniff_state_t     state, state_nx;
  logic             changed, one_hot, multi_sel, capture;
  logic [1:0]       idx;
  logic [3:0]       nibble;
  logic             known, blank;

  seg7_ca_decode u_dec (.pattern(s_seg), .nibble(nibble), .known(known), .blank(blank));

`ifdef SEG7_SNIFF_DP_EN
  logic s_dp, p_dp;
  assign changed = (s_seg != p_seg) || (s_sel != p_sel) || (s_dp != p_dp);
`else
  logic unused_dp;
  assign unused_dp = dp;
  assign changed   = (s_seg != p_seg) || (s_sel != p_sel);
`endif

  assign one_hot   = ($countones(~s_sel) == 1);
  assign multi_sel = ($countones(~s_sel) > 1);
  assign idx       = sel_index(s_sel);
  assign seen_upd  = seen | (4'b0001 << idx);
  assign HEX_out   = hex_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    if (!one_hot) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = SETTLE;
          cnt_nx   = '0;
        end
        SETTLE: begin
          if (changed) cnt_nx = '0;
          else begin
            cnt_nx = cnt + 8'd1;
            if (cnt == CAP_AT) begin
              state_nx = CAPTURED;
              capture  = 1'b1;
            end
          end
        end
        CAPTURED: begin
          if (changed) begin
            state_nx = SETTLE;
            cnt_nx   = '0;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg      <= '1;
      p_seg      <= '1;
      s_sel      <= '1;
      p_sel      <= '1;
      state      <= IDLE;
      cnt        <= '0;
      hex_q      <= '0;
      valid      <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
      seen       <= '0;
    end else begin
      s_seg      <= Segments;
      p_seg      <= s_seg;
      s_sel      <= SEL;
      p_sel      <= s_sel;
      state      <= state_nx;
      cnt        <= cnt_nx;
      frame_done <= 1'b0;
      if (multi_sel || (capture && !known && !blank)) err <= 1'b1;
      if (capture) begin
        valid[idx] <= known;
        if (known) hex_q[idx] <= nibble;
        // Blank and unknown glyphs still count towards frame completion.
        if (seen_upd == 4'b1111) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_upd;
        end
      end
    end
  end

`ifdef SEG7_SNIFF_DP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      s_dp   <= 1'b1;
      p_dp   <= 1'b1;
      dp_out <= '0;
    end else begin
      s_dp <= dp;
      p_dp <= s_dp;
      if (capture) dp_out[idx] <= ~s_dp;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_ca_sniffer.sv
// Directed-vector bench for seg7_ca_sniffer (default STABLE_CYCLES = 4).
module tb_seg7_ca_sniffer;

  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] GB = 7'b1111111;
  localparam logic [6:0] GX = 7'b0101010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  Segments = 7'b1111111;
  logic        dp = 1'b1;
  logic [3:0]  SEL = 4'b1111;
  logic [15:0] HEX_out;
  logic [3:0]  valid;
  logic        err;
  logic        frame_done;
`ifdef SEG7_SNIFF_DP_EN
  logic [3:0]  dp_out;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg7_ca_sniffer dut (
    .clk(clk), .rst(rst), .Segments(Segments), .dp(dp), .SEL(SEL),
    .HEX_out(HEX_out), .valid(valid), .err(err), .frame_done(frame_done)
`ifdef SEG7_SNIFF_DP_EN
    , .dp_out(dp_out)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic [6:0] g, input logic d);
    SEL = s; Segments = g; dp = d;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    int any_valid;

    // reset state
    drive(4'b1111, GB, 1'b1);
    tick(2);
    rst = 1'b0;
    chk("rst_hex", HEX_out, 16'h0000);
    chk("rst_valid", valid, 4'b0000);
    chk("rst_err", err, 1'b0);
    chk("rst_fd", frame_done, 1'b0);

    // single glyph '3' on digit 0: capture at edge 5, not before
    drive(4'b1110, G3, 1'b1);
    tick(4);
    chk("d0_early_valid", valid, 4'b0000);
    tick(1);
    chk("d0_hex", HEX_out[3:0], 4'h3);
    chk("d0_valid", valid, 4'b0001);
    chk("d0_err", err, 1'b0);
    tick(5);
    chk("d0_no_recap_fd", frame_done, 1'b0);

    // full frame 1,A,C,F -> FCA1 with one frame_done pulse
    drive(4'b1111, GB, 1'b1);
    do_rst();
    pulses = 0;
    for (int d = 0; d < 4; d++) begin
      logic [3:0] oh;
      oh = 4'b0001 << d;
      case (d)
        0: drive(~oh, G1, 1'b1);
        1: drive(~oh, GA, 1'b1);
        2: drive(~oh, GC, 1'b1);
        default: drive(~oh, GF, 1'b1);
      endcase
      for (int c = 0; c < 6; c++) begin
        tick(1);
        if (frame_done) pulses++;
      end
    end
    chk("frame_hex", HEX_out, 16'hFCA1);
    chk("frame_valid", valid, 4'b1111);
    chk("frame_pulses", pulses, 1);
    chk("frame_err", err, 1'b0);

    // blank keeps nibble, clears valid; unknown sets sticky err
    do_rst();
    drive(4'b1101, G5, 1'b1);
    tick(6);
    chk("d1_hex", HEX_out[7:4], 4'h5);
    chk("d1_valid", valid, 4'b0010);
    drive(4'b1101, GB, 1'b1);
    tick(6);
    chk("blank_valid", valid, 4'b0000);
    chk("blank_hex", HEX_out[7:4], 4'h5);
    chk("blank_err", err, 1'b0);
    drive(4'b1101, GX, 1'b1);
    tick(6);
    chk("unk_err", err, 1'b1);
    chk("unk_hex", HEX_out[7:4], 4'h5);
    chk("unk_valid", valid, 4'b0000);
    drive(4'b1110, G8, 1'b1);
    tick(6);
    chk("sticky_err", err, 1'b1);
    chk("sticky_d0", HEX_out[3:0], 4'h8);
    do_rst();
    chk("err_cleared", err, 1'b0);

    // multiple selects: no capture, err set
    drive(4'b1100, G3, 1'b1);
    tick(10);
    chk("multi_valid", valid, 4'b0000);
    chk("multi_hex", HEX_out, 16'h0000);
    chk("multi_err", err, 1'b1);

    // glyph changing every 3 cycles never captures
    do_rst();
    any_valid = 0;
    for (int k = 0; k < 8; k++) begin
      drive(4'b1110, (k % 2) ? G1 : G7, 1'b1);
      for (int c = 0; c < 3; c++) begin
        tick(1);
        if (valid != 4'b0000) any_valid++;
      end
    end
    chk("flicker_valid", any_valid, 0);
    chk("flicker_hex", HEX_out, 16'h0000);
    chk("flicker_err", err, 1'b0);

    // reset mid-settle aborts; fresh interval afterwards
    drive(4'b1111, GB, 1'b1);
    tick(3);
    drive(4'b1011, G7, 1'b1);
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_hex", HEX_out, 16'h0000);
    chk("midrst_valid", valid, 4'b0000);
    chk("midrst_err", err, 1'b0);
    chk("midrst_fd", frame_done, 1'b0);
    tick(4);
    chk("midrst_early", valid, 4'b0000);
    tick(1);
    chk("midrst_valid2", valid, 4'b0100);
    chk("midrst_hex2", HEX_out[11:8], 4'h7);

`ifdef SEG7_SNIFF_DP_EN
    do_rst();
    drive(4'b1011, G8, 1'b0);
    tick(6);
    chk("dp_out", dp_out, 4'b0100);
    chk("dp_hex", HEX_out[11:8], 4'h8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
